// File: rtl/dcache_pkg.sv
// Shared types, geometry and address-field helpers for the direct-mapped data cache.
package dcache_pkg;

  localparam int DEF_INDEX_BITS = 4;
  localparam int DEF_WORD_BITS  = 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  function automatic int tag_bits(input int ib, input int wb);
    return 32 - ib - wb - 2;
  endfunction

  function automatic int line_width(input int wb);
    return 32 * (2 ** wb);
  endfunction

  localparam int TAG_BITS    = tag_bits(DEF_INDEX_BITS, DEF_WORD_BITS);
  localparam int OFFSET_BITS = DEF_WORD_BITS + 2;
  localparam int LINE_W      = line_width(DEF_WORD_BITS);

  // Field helpers return right-justified values; callers size-cast to their field width.
  function automatic logic [31:0] addr_offset(input logic [31:0] a, input int wb);
    return (a >> 2) & ((32'd1 << wb) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_index(input logic [31:0] a, input int ib, input int wb);
    return (a >> (wb + 2)) & ((32'd1 << ib) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_tag(input logic [31:0] a, input int ib, input int wb);
    return a >> (ib + wb + 2);
  endfunction

endpackage

// File: rtl/dcache_if.sv
// Memory-stage request bus plus line-granular main-memory port of the data cache.
interface dcache_if #(parameter int LINE_W = 128);
  logic              cpu_valid;
  logic              cpu_op;
  logic [31:0]       cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [31:0]       cpu_rdata;
  logic              cache_ready;
  logic              cache_busy;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  cpu_valid, cpu_op, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    output cpu_rdata, cache_ready, cache_busy, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_valid, cpu_op, cpu_addr, cpu_wdata, mem_rdata, mem_ready,
    input  cpu_rdata, cache_ready, cache_busy, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: async read, sync word write (store hit) and line write (refill).
module dcache_array #(
  parameter int INDEX_BITS = 4,
  parameter int WORD_BITS  = 2,
  parameter int TAG_W      = 24,
  parameter int LINE_W     = 128
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [INDEX_BITS-1:0] i_idx,
  output logic                  o_valid,
  output logic                  o_dirty,
  output logic [TAG_W-1:0]      o_tag,
  output logic [LINE_W-1:0]     o_line,
  input  logic                  i_word_we,
  input  logic [WORD_BITS-1:0]  i_word_off,
  input  logic [31:0]           i_word_data,
  input  logic                  i_line_we,
  input  logic [TAG_W-1:0]      i_line_tag,
  input  logic [LINE_W-1:0]     i_line_data
);
  localparam int NLINES = 1 << INDEX_BITS;

  logic [NLINES-1:0] r_valid;
  logic [NLINES-1:0] r_dirty;
  logic [TAG_W-1:0]  r_tag  [NLINES];
  logic [LINE_W-1:0] r_data [NLINES];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_line  = r_data[i_idx];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_line_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_word_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Contents are meaningless until valid is set, so no reset here.
  always_ff @(posedge CLK) begin
    if (i_line_we) begin
      r_tag[i_idx]  <= i_line_tag;
      r_data[i_idx] <= i_line_data;
    end else if (i_word_we) begin
      r_data[i_idx][32*i_word_off +: 32] <= i_word_data;
    end
  end
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate D-cache: zero-latency hits, FSM-driven writeback and refill.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int INDEX_BITS = DEF_INDEX_BITS,
  parameter int WORD_BITS  = DEF_WORD_BITS,
  parameter int LINE_W     = 32 * (2 ** WORD_BITS)
) (
  input  logic     CLK,
  input  logic     Reset,
  dcache_if.slave  bus
);
  localparam int TAG_W = 32 - INDEX_BITS - WORD_BITS - 2;

  state_e                r_state, w_next;
  logic [INDEX_BITS-1:0] r_miss_idx, w_req_idx, w_idx;
  logic [TAG_W-1:0]      r_miss_tag, w_req_tag, w_tag;
  logic [WORD_BITS-1:0]  w_off;
  logic                  w_valid, w_dirty, w_hit;
  logic [LINE_W-1:0]     w_line;
  logic [31:0]           w_word;
  logic                  w_mem_req, w_mem_we;
  logic [31:0]           w_mem_addr;
  logic [LINE_W-1:0]     w_mem_wdata;

  assign w_req_idx = INDEX_BITS'(addr_index(bus.cpu_addr, INDEX_BITS, WORD_BITS));
  assign w_req_tag = TAG_W'(addr_tag(bus.cpu_addr, INDEX_BITS, WORD_BITS));
  assign w_off     = WORD_BITS'(addr_offset(bus.cpu_addr, WORD_BITS));

  // The miss index/tag are latched so the memory transaction stays stable even if the core drops the request.
  assign w_idx = (r_state == IDLE) ? w_req_idx : r_miss_idx;

  dcache_array #(
    .INDEX_BITS(INDEX_BITS), .WORD_BITS(WORD_BITS), .TAG_W(TAG_W), .LINE_W(LINE_W)
  ) u_array (
    .CLK         (CLK),
    .Reset       (Reset),
    .i_idx       (w_idx),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_tag),
    .o_line      (w_line),
    .i_word_we   (w_hit & ~bus.cpu_op),
    .i_word_off  (w_off),
    .i_word_data (bus.cpu_wdata),
    .i_line_we   ((r_state == ALLOCATE) & bus.mem_ready),
    .i_line_tag  (r_miss_tag),
    .i_line_data (bus.mem_rdata)
  );

  assign w_hit  = bus.cpu_valid & w_valid & (w_tag == w_req_tag) & (r_state == IDLE);
  assign w_word = w_line[32*w_off +: 32];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_miss_idx <= '0;
      r_miss_tag <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        r_miss_idx <= w_req_idx;
        r_miss_tag <= w_req_tag;
      end
    end
  end

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (bus.cpu_valid && !w_hit)
          w_next = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
      end
      WRITEBACK: begin
        w_mem_req   = 1'b1;
        w_mem_we    = 1'b1;
        w_mem_addr  = {w_tag, r_miss_idx, {(WORD_BITS+2){1'b0}}};
        w_mem_wdata = w_line;
        if (bus.mem_ready) w_next = ALLOCATE;
      end
      ALLOCATE: begin
        w_mem_req  = 1'b1;
        w_mem_addr = {r_miss_tag, r_miss_idx, {(WORD_BITS+2){1'b0}}};
        if (bus.mem_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign bus.cache_ready = w_hit;
  assign bus.cpu_rdata   = w_hit ? w_word : 32'h0;
  assign bus.cache_busy  = (r_state != IDLE);
  assign bus.mem_req     = w_mem_req;
  assign bus.mem_we      = w_mem_we;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_wdata   = w_mem_wdata;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a line-granular memory model and request/transaction scoreboards.
module tb_dcache_controller;
  localparam int LW  = 128;
  localparam int LAT = 3;

  typedef struct {
    logic          we;
    logic [31:0]   addr;
    logic [LW-1:0] data;
  } txn_t;

  logic CLK = 1'b0;
  logic Reset;
  always #5 CLK = ~CLK;

  dcache_if #(.LINE_W(LW)) bus ();
  dcache_controller dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  int            n_tests = 0;
  int            n_fail  = 0;
  txn_t          exp_mem [$];
  logic [31:0]   exp_rd  [$];
  logic [LW-1:0] mem_store [logic [31:0]];
  int            stray_req = 0;
  int            mem_cnt, mem_seen;

  function automatic logic [31:0] init_word(input logic [31:0] a, input int i);
    return {16'hC0DE, a[15:4], 4'(i)};
  endfunction

  function automatic logic [LW-1:0] init_line(input logic [31:0] a);
    logic [LW-1:0] l;
    for (int i = 0; i < 4; i++) l[32*i +: 32] = init_word(a, i);
    return l;
  endfunction

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory transaction scoreboard, sampled every cycle so held fields are checked throughout.
  task automatic chk_mem();
    txn_t t;
    if (bus.mem_req) begin
      check("mem_txn_expected", LW'(exp_mem.size() != 0), LW'(1));
      if (exp_mem.size() != 0) begin
        t = exp_mem[0];
        check("mem_we", LW'(bus.mem_we), LW'(t.we));
        check("mem_addr", LW'(bus.mem_addr), LW'(t.addr));
        if (t.we) check("mem_wdata", bus.mem_wdata, t.data);
        if (bus.mem_ready) void'(exp_mem.pop_front());
      end
    end
  endtask

  task automatic do_req(input logic op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rdata, input int exp_lat, input string tag);
    int          cyc;
    logic        done;
    logic [31:0] e;
    @(posedge CLK); #1;
    bus.cpu_valid = 1'b1;
    bus.cpu_op    = op;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    exp_rd.push_back(exp_rdata);
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      chk_mem();
      if (cyc == 2 && exp_lat > 1) check({tag, "_busy"}, LW'(bus.cache_busy), LW'(1));
      if (bus.cache_ready) begin
        done = 1'b1;
        e = exp_rd.pop_front();
        if (op) check({tag, "_rdata"}, LW'(bus.cpu_rdata), LW'(e));
        check({tag, "_latency"}, LW'(cyc), LW'(exp_lat));
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, LW'(cyc), LW'(exp_lat));
      void'(exp_rd.pop_front());
    end
    @(posedge CLK); #1;
    bus.cpu_valid = 1'b0;
    bus.cpu_op    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    check({tag, "_ready"}, LW'(bus.cache_ready), '0);
    check({tag, "_busy"},  LW'(bus.cache_busy),  '0);
    check({tag, "_req"},   LW'(bus.mem_req),     '0);
    check({tag, "_we"},    LW'(bus.mem_we),      '0);
    check({tag, "_addr"},  LW'(bus.mem_addr),    '0);
    check({tag, "_wdata"}, bus.mem_wdata,        '0);
    check({tag, "_rdata"}, LW'(bus.cpu_rdata),   '0);
  endtask

  // Memory model: answers each transaction LAT cycles after mem_req rises; can also emit a stray pulse.
  initial begin
    mem_cnt       = 0;
    mem_seen      = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge CLK); #1;
      bus.mem_ready = 1'b0;
      if (Reset || !bus.mem_req) begin
        mem_cnt = 0;
        if (!Reset && stray_req != mem_seen) begin
          mem_seen      = stray_req;
          bus.mem_ready = 1'b1;
          bus.mem_rdata = {LW{1'b1}};
        end
      end else begin
        mem_cnt++;
        if (mem_cnt == LAT) begin
          mem_cnt       = 0;
          bus.mem_ready = 1'b1;
          if (bus.mem_we) mem_store[bus.mem_addr] = bus.mem_wdata;
          else bus.mem_rdata = mem_store.exists(bus.mem_addr) ? mem_store[bus.mem_addr]
                                                              : init_line(bus.mem_addr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LW-1:0] vic;
    Reset         = 1'b1;
    bus.cpu_valid = 1'b0;
    bus.cpu_op    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_idle_outputs("reset");
    @(posedge CLK); #1;
    Reset = 1'b0;

    exp_mem.push_back('{we: 1'b0, addr: 32'h0000_0100, data: '0});
    do_req(1'b1, 32'h0000_0104, 32'h0, init_word(32'h100, 1), 1 + LAT + 1, "cold_miss");
    do_req(1'b1, 32'h0000_010C, 32'h0, init_word(32'h100, 3), 1, "read_hit");

    @(negedge CLK);
    stray_req++;
    repeat (2) begin
      @(negedge CLK);
      check("stray_busy", LW'(bus.cache_busy), '0);
      check("stray_req",  LW'(bus.mem_req),    '0);
    end
    do_req(1'b1, 32'h0000_010C, 32'h0, init_word(32'h100, 3), 1, "hit_after_stray");

    do_req(1'b0, 32'h0000_0108, 32'hDEAD_BEEF, 32'h0, 1, "store_hit");
    do_req(1'b1, 32'h0000_0108, 32'h0, 32'hDEAD_BEEF, 1, "load_after_store");

    vic = init_line(32'h100);
    vic[95:64] = 32'hDEAD_BEEF;
    exp_mem.push_back('{we: 1'b1, addr: 32'h0000_0100, data: vic});
    exp_mem.push_back('{we: 1'b0, addr: 32'h0000_1100, data: '0});
    do_req(1'b1, 32'h0000_1108, 32'h0, init_word(32'h1100, 2), 1 + 2*LAT + 1, "dirty_evict");

    exp_mem.push_back('{we: 1'b0, addr: 32'h0000_0200, data: '0});
    do_req(1'b0, 32'h0000_0200, 32'h1234_5678, 32'h0, 1 + LAT + 1, "store_miss");
    do_req(1'b1, 32'h0000_0200, 32'h0, 32'h1234_5678, 1, "load_store_miss");

    // Reset lands while the refill of 0x450 is outstanding.
    exp_mem.push_back('{we: 1'b0, addr: 32'h0000_0450, data: '0});
    @(posedge CLK); #1;
    bus.cpu_valid = 1'b1;
    bus.cpu_op    = 1'b1;
    bus.cpu_addr  = 32'h0000_0454;
    repeat (2) begin
      @(negedge CLK);
      chk_mem();
    end
    check("abort_in_allocate", LW'(bus.cache_busy), LW'(1));
    @(posedge CLK); #1;
    Reset         = 1'b1;
    bus.cpu_valid = 1'b0;
    bus.cpu_addr  = '0;
    @(negedge CLK);
    chk_mem();
    @(negedge CLK);
    chk_idle_outputs("mid_reset");
    check("abort_pending", LW'(exp_mem.size()), LW'(1));
    void'(exp_mem.pop_front());
    @(posedge CLK); #1;
    Reset = 1'b0;

    exp_mem.push_back('{we: 1'b0, addr: 32'h0000_0100, data: '0});
    do_req(1'b1, 32'h0000_010C, 32'h0, init_word(32'h100, 3), 1 + LAT + 1, "miss_after_reset");
    do_req(1'b1, 32'h0000_0108, 32'h0, 32'hDEAD_BEEF, 1, "writeback_persisted");

    check("mem_txns_drained", LW'(exp_mem.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
